// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of one single-port read-first block RAM.
// Latency: grant is combinational; response comes READ_LATENCY cycles after the transfer edge.
// Backpressure: a requester holds req_valid and its payload until req_ready; responses never stall.
//
// Ports:
//   clk_in, rst_in          clock and asynchronous active-high reset
//   req_valid/req_ready     per-requester handshake (bit n = requester n)
//   req_we/addr/wdata       per-requester payload; requester n sits in slice n
//   rsp_valid/rsp_rdata     one-cycle response strobe per requester plus shared data
//   ram_*                   single-port RAM connection (read-first, READ_LATENCY 1 or 2)
//
// Build option: define BRAM_ARB_FIXED_PRIORITY_EN to make requester 0 always win
// simultaneous requests; the round-robin pointer is then not built.
module bram_port_arbiter #(
  parameter int RAM_WIDTH    = 16,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [2*ADDR_W-1:0]    req_addr,
  input  logic [2*RAM_WIDTH-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [RAM_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]      ram_addra,
  output logic [RAM_WIDTH-1:0]   ram_dina,
  output logic                   ram_wea,
  output logic                   ram_ena,
  output logic                   ram_regcea,
  output logic                   ram_rsta,
  input  logic [RAM_WIDTH-1:0]   ram_douta
);

  logic [1:0]              gnt;
  logic                    sel;
  logic                    xfer;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_own;

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
  // Requester 0 wins every contention.
  always_comb begin
    gnt = 2'b00;
    if (!rst_in) begin
      if (req_valid[0])      gnt = 2'b01;
      else if (req_valid[1]) gnt = 2'b10;
    end
  end
`else
  // rr_ptr names the requester favoured on contention; it flips to the
  // other requester after every completed transfer.
  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (!rst_in) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr <= 1'b0;
    end else if (xfer) begin
      rr_ptr <= gnt[0];
    end
  end
`endif

  // A grant is only ever raised for a valid requester, so any grant is a transfer.
  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel       = gnt[1];

  assign ram_ena    = xfer;
  assign ram_wea    = xfer && req_we[sel];
  assign ram_addra  = sel ? req_addr[2*ADDR_W-1:ADDR_W]          : req_addr[ADDR_W-1:0];
  assign ram_dina   = sel ? req_wdata[2*RAM_WIDTH-1:RAM_WIDTH]   : req_wdata[RAM_WIDTH-1:0];
  assign ram_regcea = 1'b1;
  assign ram_rsta   = 1'b0;

  // Owner/valid shift line matching the RAM read latency; stage 0 is loaded
  // on the transfer edge, the last stage lines up with ram_douta.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= xfer;
      pipe_own[0] <= sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign rsp_valid = pipe_vld[READ_LATENCY-1] ?
                     (pipe_own[READ_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
  // Read-first RAM: for writes this returns the contents before the write.
  assign rsp_rdata = ram_douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;

  // DUT a: READ_LATENCY=1, DUT b: READ_LATENCY=2, identical stimulus.
  logic [1:0]  rdy_a, rdy_b, rspv_a, rspv_b;
  logic [15:0] rdat_a, rdat_b, dina_a, dina_b, douta_a, douta_b;
  logic [9:0]  addra_a, addra_b;
  logic        wea_a, wea_b, ena_a, ena_b, regce_a, regce_b, rsta_a, rsta_b;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  bram_port_arbiter #(.RAM_WIDTH(16), .ADDR_W(10), .READ_LATENCY(1)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_ready(rdy_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv_a), .rsp_rdata(rdat_a), .ram_addra(addra_a), .ram_dina(dina_a),
    .ram_wea(wea_a), .ram_ena(ena_a), .ram_regcea(regce_a), .ram_rsta(rsta_a),
    .ram_douta(douta_a));

  bram_port_arbiter #(.RAM_WIDTH(16), .ADDR_W(10), .READ_LATENCY(2)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_ready(rdy_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv_b), .rsp_rdata(rdat_b), .ram_addra(addra_b), .ram_dina(dina_b),
    .ram_wea(wea_b), .ram_ena(ena_b), .ram_regcea(regce_b), .ram_rsta(rsta_b),
    .ram_douta(douta_b));

  // Read-first RAM driven by DUT a; both DUTs issue the same RAM traffic.
  logic [15:0] mem [0:1023] = '{default: 16'h0000};
  logic [15:0] dq1 = 16'h0000;
  logic [15:0] dq2 = 16'h0000;
  always @(posedge clk_in) begin
    if (ena_a) begin
      dq1 <= mem[addra_a];
      if (wea_a) mem[addra_a] <= dina_a;
    end
    dq2 <= dq1;
  end
  assign douta_a = dq1;
  assign douta_b = dq2;

  // Reference model state.
  logic [15:0] mm [0:1023];
  bit          pend [2];
  bit          p_we [2];
  logic [9:0]  p_addr [2];
  logic [15:0] p_wd [2];
  int          last_g;
  int          cyc;
  logic [1:0]  e_v1 [8];
  logic [15:0] e_d1 [8];
  logic [1:0]  e_v2 [8];
  logic [15:0] e_d2 [8];
  logic [1:0]  gnt_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int n, input bit we, input logic [9:0] a, input logic [15:0] d);
    pend[n] = 1'b1;
    p_we[n] = we;
    p_addr[n] = a;
    p_wd[n] = d;
  endtask

  // One clock cycle: drive held requests, check combinational outputs and
  // due responses, then account for the transfer the next edge completes.
  task automatic step(input bit rst);
    int g;
    int s;
    bit ew;
    logic [1:0]  exp_rdy;
    logic [15:0] d;
    @(negedge clk_in);
    rst_in    = rst;
    req_valid = {pend[1], pend[0]};
    req_we    = {p_we[1], p_we[0]};
    req_addr  = {p_addr[1], p_addr[0]};
    req_wdata = {p_wd[1], p_wd[0]};
    #1;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        e_v1[i] = 2'b00;
        e_v2[i] = 2'b00;
      end
      last_g = 1;
    end
    g = -1;
    if (!rst) begin
      if (pend[0] && pend[1]) g = FIXED ? 0 : ((last_g == 0) ? 1 : 0);
      else if (pend[0])       g = 0;
      else if (pend[1])       g = 1;
    end
    exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
    ew = (g >= 0) ? p_we[g] : 1'b0;
    chk("ready_lat1", 32'(rdy_a), 32'(exp_rdy));
    chk("ready_lat2", 32'(rdy_b), 32'(exp_rdy));
    chk("ram_ena", 32'({ena_a, ena_b}), (g >= 0) ? 32'd3 : 32'd0);
    chk("ram_wea", 32'({wea_a, wea_b}), ew ? 32'd3 : 32'd0);
    chk("ram_ties", 32'({regce_a, rsta_a, regce_b, rsta_b}), 32'b1010);
    if (g >= 0) begin
      chk("ram_addr_lat1", 32'(addra_a), 32'(p_addr[g]));
      chk("ram_addr_lat2", 32'(addra_b), 32'(p_addr[g]));
      if (ew) chk("ram_din", 32'({dina_a, dina_b}), 32'({p_wd[g], p_wd[g]}));
    end
    s = cyc % 8;
    chk("rsp_valid_lat1", 32'(rspv_a), 32'(e_v1[s]));
    chk("rsp_valid_lat2", 32'(rspv_b), 32'(e_v2[s]));
    if (e_v1[s] != 2'b00) chk("rsp_data_lat1", 32'(rdat_a), 32'(e_d1[s]));
    if (e_v2[s] != 2'b00) chk("rsp_data_lat2", 32'(rdat_b), 32'(e_d2[s]));
    e_v1[s] = 2'b00;
    e_v2[s] = 2'b00;
    if (g >= 0) begin
      d = mm[p_addr[g]];
      if (p_we[g]) mm[p_addr[g]] = p_wd[g];
      e_v1[(cyc + 1) % 8] = 2'(1 << g);
      e_d1[(cyc + 1) % 8] = d;
      e_v2[(cyc + 2) % 8] = 2'(1 << g);
      e_d2[(cyc + 2) % 8] = d;
      last_g = g;
      pend[g] = 1'b0;
    end
    gnt_obs = rdy_a;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    req_valid = 2'b00;
    req_we = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 1024; i++) mm[i] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      e_v1[i] = 2'b00; e_v2[i] = 2'b00; e_d1[i] = '0; e_d2[i] = '0;
    end
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; p_we[n] = 1'b0; p_addr[n] = '0; p_wd[n] = '0;
    end
    last_g = 1;
    cyc = 0;

    // Reset with requests held: nothing may be granted.
    step(1'b1);
    arm(0, 1'b0, 10'd1, 16'h0);
    arm(1, 1'b0, 10'd2, 16'h0);
    step(1'b1);
    step(1'b1);
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) step(1'b0);

    // Both requesters hold reads: alternate 0,1,... (fixed priority: always 0).
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < 2; n++) if (!pend[n]) arm(n, 1'b0, 10'(8 + n), 16'h0);
      step(1'b0);
      chk("contend_grant", 32'(gnt_obs), FIXED ? 32'd1 : ((i % 2 == 0) ? 32'd1 : 32'd2));
    end
    for (int i = 0; i < 4; i++) step(1'b0);

    // Requester 0 writes 0xABCD to addr 5, reads it back with no bubble.
    arm(0, 1'b1, 10'd5, 16'hABCD);
    step(1'b0);
    chk("wr_grant", 32'(gnt_obs), 32'd1);
    arm(0, 1'b0, 10'd5, 16'h0);
    step(1'b0);
    chk("rd_grant", 32'(gnt_obs), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Requester 1 reads the top address alone.
    arm(1, 1'b0, 10'h3FF, 16'h0);
    step(1'b0);
    chk("top_addr_grant", 32'(gnt_obs), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Reset one cycle after a read by requester 0: in-flight response is
    // dropped and the first grant after release goes to requester 0.
    arm(0, 1'b0, 10'd3, 16'h0);
    step(1'b0);
    arm(0, 1'b0, 10'd4, 16'h0);
    arm(1, 1'b0, 10'd6, 16'h0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("post_reset_grant", 32'(gnt_obs), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 99) < 55)
          arm(n, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom_range(0, 7)),
              16'($urandom));
      end
      step(1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 16, data width of the shared RAM.
REQ-002 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-003 SHALL have parameter READ_LATENCY, default 1; legal values 1 (LOW_LATENCY RAM) or 2 (HIGH_PERFORMANCE RAM).
REQ-004 SHALL have one clock, clk_in, and an asynchronous active-high reset, rst_in.
REQ-005 SHALL have port clk_in, input, 1 bit: clock for all state and for the RAM.
REQ-006 SHALL have port rst_in, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have ports req_valid[1:0], input, 2 bits: per-requester request valid.
REQ-008 SHALL have ports req_ready[1:0], output, 2 bits: per-requester grant, combinational.
REQ-009 SHALL have port req_we[1:0], input, 2 bits: per-requester write enable.
REQ-010 SHALL have port req_addr, input, 2*ADDR_W bits: requester n at slice n.
REQ-011 SHALL have port req_wdata, input, 2*RAM_WIDTH bits: requester n at slice n.
REQ-012 SHALL have ports rsp_valid[1:0], output, 2 bits: per-requester response strobe.
REQ-013 SHALL have port rsp_rdata, output, RAM_WIDTH bits: shared response data, qualified by rsp_valid.
REQ-014 SHALL have ports ram_addra (ADDR_W), ram_dina (RAM_WIDTH), ram_wea, ram_ena, ram_regcea, ram_rsta, all outputs, plus ram_douta (RAM_WIDTH) input, connecting to the single-port read-first RAM.

Function
REQ-015 SHALL accept at most one transaction per cycle; transfer occurs when req_valid[n] and req_ready[n] are both high at the rising clk_in edge.
REQ-016 SHALL, with a single valid requester, grant it in the same cycle, with no bubble between back-to-back transfers.
REQ-017 SHALL, with both requesters valid, grant the requester not granted most recently (round-robin), pointer reset to favour requester 0.
REQ-018 SHALL update the round-robin pointer only on a completed transfer.
REQ-019 SHALL drive ram_ena = OR of req_ready, and ram_addra/ram_dina/ram_wea combinationally from the granted requester; ram_wea = 0 when no grant.
REQ-020 SHALL tie ram_regcea = 1 and ram_rsta = 0.
REQ-021 SHALL issue a response for every transfer, read or write, exactly READ_LATENCY cycles after the transfer edge: rsp_valid[n] high for one cycle, rsp_rdata = ram_douta (prior contents for writes, read-first).
REQ-022 SHALL track response ownership in a READ_LATENCY-deep owner/valid shift pipeline; at most one rsp_valid bit is high per cycle.
REQ-023 SHALL require requesters to hold req_valid and payload stable until granted; behaviour on withdrawal is unspecified.
REQ-024 SHALL never stall responses; no response backpressure exists.

Reset
REQ-025 SHALL, while rst_in is high, force req_ready = 0, ram_ena = 0, ram_wea = 0, rsp_valid = 0, and set the round-robin pointer to favour requester 0.
REQ-026 SHALL clear the owner/valid pipeline asynchronously; transfers in flight at reset produce no response after reset release.
REQ-027 SHALL not alter RAM contents on reset.

Configuration
REQ-028 SHALL honour macro BRAM_ARB_FIXED_PRIORITY_EN: when defined, requester 0 always wins simultaneous requests and the round-robin pointer is absent; when undefined, round-robin per REQ-017.

Verification
REQ-029 Single requester 0 writes 0xABCD to addr 5 then reads addr 5 on consecutive cycles -> both granted without bubble; write response returns old value 0x0000, read response returns 0xABCD, each READ_LATENCY cycles after its transfer.
REQ-030 Both requesters hold valid reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each rsp_valid routes to the correct requester.
REQ-031 With BRAM_ARB_FIXED_PRIORITY_EN, both hold valid 4 cycles -> requester 0 granted all 4, requester 1 never granted.
REQ-032 rst_in asserted 1 cycle after a read transfer (READ_LATENCY=2) -> no rsp_valid after reset release; first grant after release goes to requester 0.
REQ-033 Requester 1 reads addr 0x3FF (top address) while requester 0 idle, READ_LATENCY=1 and 2 -> rsp_valid[1] exactly 1 and 2 cycles after transfer respectively.
REQ-034 No requests for 10 cycles -> ram_ena = 0 and rsp_valid = 0 throughout.
